// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming top-2 argmax classifier.
package argmax_pkg;

  // Widest score the compare helper handles; BITWIDTH must stay below this.
  localparam int unsigned MAX_BW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of scan groups needed to cover all classes (ceiling division).
  function automatic int unsigned groups(input int unsigned classes, input int unsigned lanes);
    return (classes + lanes - 1) / lanes;
  endfunction

  // Strict greater-than on pre-extended operands; the caller extends the
  // scores to MAX_BW according to the signedness it uses.
  function automatic logic gt(input logic [MAX_BW-1:0] a,
                              input logic [MAX_BW-1:0] b,
                              input logic              signed_mode);
    logic r;
    if (signed_mode) begin
      r = ($signed(a) > $signed(b));
    end else begin
      r = (a > b);
    end
    return r;
  endfunction

endpackage

// File: rtl/argmax_lane_cmp.sv
// Combinational insert unit: folds one element into a running top-2 pair.
// Strict comparisons keep the lower index on ties, matching an ascending scan.
module argmax_lane_cmp
  import argmax_pkg::*;
#(
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned SIGNED      = 0
) (
  input  logic [BITWIDTH-1:0]    t1_val_i,
  input  logic [INDEX_WIDTH-1:0] t1_idx_i,
  input  logic                   t1_full_i,
  input  logic [BITWIDTH-1:0]    t2_val_i,
  input  logic [INDEX_WIDTH-1:0] t2_idx_i,
  input  logic                   t2_full_i,
  input  logic                   elem_en_i,
  input  logic [BITWIDTH-1:0]    elem_val_i,
  input  logic [INDEX_WIDTH-1:0] elem_idx_i,
  output logic [BITWIDTH-1:0]    t1_val_o,
  output logic [INDEX_WIDTH-1:0] t1_idx_o,
  output logic                   t1_full_o,
  output logic [BITWIDTH-1:0]    t2_val_o,
  output logic [INDEX_WIDTH-1:0] t2_idx_o,
  output logic                   t2_full_o
);

  localparam logic SMODE = (SIGNED != 0);

  // Extend a score to the helper width, sign-filling only in signed mode.
  function automatic logic [MAX_BW-1:0] ext(input logic [BITWIDTH-1:0] v);
    logic sbit;
    sbit = SMODE & v[BITWIDTH-1];
    return {{(MAX_BW-BITWIDTH){sbit}}, v};
  endfunction

  logic gt1_s;
  logic gt2_s;

  assign gt1_s = gt(ext(elem_val_i), ext(t1_val_i), SMODE);
  assign gt2_s = gt(ext(elem_val_i), ext(t2_val_i), SMODE);

  // Insert the element: new maximum demotes old top1, else it may replace top2.
  always_comb begin
    t1_val_o  = t1_val_i;
    t1_idx_o  = t1_idx_i;
    t1_full_o = t1_full_i;
    t2_val_o  = t2_val_i;
    t2_idx_o  = t2_idx_i;
    t2_full_o = t2_full_i;
    if (elem_en_i) begin
      if (!t1_full_i || gt1_s) begin
        t1_val_o  = elem_val_i;
        t1_idx_o  = elem_idx_i;
        t1_full_o = 1'b1;
        t2_val_o  = t1_val_i;
        t2_idx_o  = t1_idx_i;
        t2_full_o = t1_full_i;
      end else if (!t2_full_i || gt2_s) begin
        t2_val_o  = elem_val_i;
        t2_idx_o  = elem_idx_i;
        t2_full_o = 1'b1;
      end else begin
        t2_full_o = t2_full_i;
      end
    end else begin
      t1_full_o = t1_full_i;
    end
  end

endmodule

// File: rtl/argmax_topk.sv
// Streaming top-2 classifier: captures a score vector, scans it LANES
// elements per cycle and presents top1/top2 with their margin.
module argmax_topk
  import argmax_pkg::*;
#(
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned CLASSES     = 10,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned LANES       = 2,
  parameter int unsigned SIGNED      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BITWIDTH*CLASSES-1:0]   data_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INDEX_WIDTH-1:0]        top1_idx_o,
  output logic [BITWIDTH-1:0]           top1_val_o,
  output logic [INDEX_WIDTH-1:0]        top2_idx_o,
  output logic [BITWIDTH-1:0]           top2_val_o,
  output logic [BITWIDTH:0]             margin_o
);

  localparam int unsigned G      = groups(CLASSES, LANES);
  localparam int unsigned PADN   = G * LANES;
  localparam int unsigned GRP_W  = (G > 1) ? $clog2(G) : 1;
  // Padded element indices stay below 2*CLASSES, so one extra bit suffices.
  localparam int unsigned ELEM_W = INDEX_WIDTH + 1;
  localparam logic        SMODE  = (SIGNED != 0);

  // Extend a score by one bit for the margin subtraction.
  function automatic logic [BITWIDTH:0] sx(input logic [BITWIDTH-1:0] v);
    return {SMODE & v[BITWIDTH-1], v};
  endfunction

  state_e                      state_q, state_d;
  logic [BITWIDTH*CLASSES-1:0] data_q, data_d;
  logic [GRP_W-1:0]            grp_q, grp_d;
  logic [BITWIDTH-1:0]         w1_val_q, w1_val_d, w2_val_q, w2_val_d;
  logic [INDEX_WIDTH-1:0]      w1_idx_q, w1_idx_d, w2_idx_q, w2_idx_d;
  logic                        w1_full_q, w1_full_d, w2_full_q, w2_full_d;
  logic [INDEX_WIDTH-1:0]      r1_idx_q, r1_idx_d, r2_idx_q, r2_idx_d;
  logic [BITWIDTH-1:0]         r1_val_q, r1_val_d, r2_val_q, r2_val_d;
  logic [BITWIDTH:0]           margin_q, margin_d;
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;

  // Captured vector zero-padded so the partial last group indexes in range.
  logic [PADN*BITWIDTH-1:0]    data_pad_s;
  assign data_pad_s = (PADN*BITWIDTH)'(data_q);

  logic [BITWIDTH-1:0]    c1_val_s  [LANES+1];
  logic [INDEX_WIDTH-1:0] c1_idx_s  [LANES+1];
  logic                   c1_full_s [LANES+1];
  logic [BITWIDTH-1:0]    c2_val_s  [LANES+1];
  logic [INDEX_WIDTH-1:0] c2_idx_s  [LANES+1];
  logic                   c2_full_s [LANES+1];

  assign c1_val_s[0]  = w1_val_q;
  assign c1_idx_s[0]  = w1_idx_q;
  assign c1_full_s[0] = w1_full_q;
  assign c2_val_s[0]  = w2_val_q;
  assign c2_idx_s[0]  = w2_idx_q;
  assign c2_full_s[0] = w2_full_q;

  // One insert unit per lane, chained in ascending element order.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ELEM_W-1:0]   e_idx_s;
    logic                e_en_s;
    logic [BITWIDTH-1:0] e_val_s;

    assign e_idx_s = ELEM_W'(grp_q) * ELEM_W'(LANES) + ELEM_W'(l);
    assign e_en_s  = (e_idx_s < ELEM_W'(CLASSES));
    assign e_val_s = data_pad_s[e_idx_s*BITWIDTH +: BITWIDTH];

    argmax_lane_cmp #(
      .BITWIDTH    (BITWIDTH),
      .INDEX_WIDTH (INDEX_WIDTH),
      .SIGNED      (SIGNED)
    ) u_cmp (
      .t1_val_i   (c1_val_s[l]),
      .t1_idx_i   (c1_idx_s[l]),
      .t1_full_i  (c1_full_s[l]),
      .t2_val_i   (c2_val_s[l]),
      .t2_idx_i   (c2_idx_s[l]),
      .t2_full_i  (c2_full_s[l]),
      .elem_en_i  (e_en_s),
      .elem_val_i (e_val_s),
      .elem_idx_i (e_idx_s[INDEX_WIDTH-1:0]),
      .t1_val_o   (c1_val_s[l+1]),
      .t1_idx_o   (c1_idx_s[l+1]),
      .t1_full_o  (c1_full_s[l+1]),
      .t2_val_o   (c2_val_s[l+1]),
      .t2_idx_o   (c2_idx_s[l+1]),
      .t2_full_o  (c2_full_s[l+1])
    );
  end

  // Next-state logic: accept in IDLE, fold one group per SCAN cycle, hold in DONE.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    grp_d     = grp_q;
    w1_val_d  = w1_val_q;
    w1_idx_d  = w1_idx_q;
    w1_full_d = w1_full_q;
    w2_val_d  = w2_val_q;
    w2_idx_d  = w2_idx_q;
    w2_full_d = w2_full_q;
    r1_idx_d  = r1_idx_q;
    r1_val_d  = r1_val_q;
    r2_idx_d  = r2_idx_q;
    r2_val_d  = r2_val_q;
    margin_d  = margin_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d    = data_i;
          grp_d     = '0;
          w1_full_d = 1'b0;
          w2_full_d = 1'b0;
          state_d   = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        w1_val_d  = c1_val_s[LANES];
        w1_idx_d  = c1_idx_s[LANES];
        w1_full_d = c1_full_s[LANES];
        w2_val_d  = c2_val_s[LANES];
        w2_idx_d  = c2_idx_s[LANES];
        w2_full_d = c2_full_s[LANES];
        grp_d     = grp_q + GRP_W'(1);
        if (grp_q == GRP_W'(G - 1)) begin
          r1_idx_d = c1_idx_s[LANES];
          r1_val_d = c1_val_s[LANES];
          r2_idx_d = c2_idx_s[LANES];
          r2_val_d = c2_val_s[LANES];
          margin_d = sx(c1_val_s[LANES]) - sx(c2_val_s[LANES]);
          state_d  = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, capture, working and result registers; reset aborts any scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      grp_q       <= '0;
      w1_val_q    <= '0;
      w1_idx_q    <= '0;
      w1_full_q   <= 1'b0;
      w2_val_q    <= '0;
      w2_idx_q    <= '0;
      w2_full_q   <= 1'b0;
      r1_idx_q    <= '0;
      r1_val_q    <= '0;
      r2_idx_q    <= '0;
      r2_val_q    <= '0;
      margin_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      grp_q       <= grp_d;
      w1_val_q    <= w1_val_d;
      w1_idx_q    <= w1_idx_d;
      w1_full_q   <= w1_full_d;
      w2_val_q    <= w2_val_d;
      w2_idx_q    <= w2_idx_d;
      w2_full_q   <= w2_full_d;
      r1_idx_q    <= r1_idx_d;
      r1_val_q    <= r1_val_d;
      r2_idx_q    <= r2_idx_d;
      r2_val_q    <= r2_val_d;
      margin_q    <= margin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign top1_idx_o = r1_idx_q;
  assign top1_val_o = r1_val_q;
  assign top2_idx_o = r2_idx_q;
  assign top2_val_o = r2_val_q;
  assign margin_o   = margin_q;

endmodule

// File: doc/argmax_topk.md
# argmax_topk

Parametrised streaming top-2 classifier for the SA inference output stage. It accepts one packed vector of CLASSES scores per transaction and scans it LANES elements per cycle. It returns the index and value of the largest and second-largest score, plus their margin. It uses full valid/ready handshakes on both sides and supports signed or unsigned scores, so it can feed a downstream confidence check directly.

## Interface
Parameters:
- BITWIDTH, 8: width of one score.
- CLASSES, 10: number of scores per vector; must be ≥ 2.
- INDEX_WIDTH, 4: index width; must satisfy 2^INDEX_WIDTH ≥ CLASSES.
- LANES, 2: elements compared per scan cycle, 1..CLASSES.
- SIGNED, 0: 0 = unsigned scores, 1 = two's-complement scores.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: data_i holds a vector.
- in_ready, output, 1: block accepts a vector this cycle.
- data_i, input, BITWIDTH*CLASSES: score i occupies bits [i*BITWIDTH +: BITWIDTH].
- out_valid, output, 1: result registers hold a valid result.
- out_ready, input, 1: consumer accepts the result.
- top1_idx_o, output, INDEX_WIDTH: index of the maximum score.
- top1_val_o, output, BITWIDTH: maximum score.
- top2_idx_o, output, INDEX_WIDTH: index of the second score.
- top2_val_o, output, BITWIDTH: second score.
- margin_o, output, BITWIDTH+1: top1_val − top2_val, unsigned, always ≥ 0.

## Operation
- States are IDLE, SCAN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, data_i is captured into an internal register, the group counter is cleared, both top slots are marked empty, and the state moves to SCAN.
- SCAN:
  - Each cycle processes group g, which covers elements g*LANES to g*LANES+LANES−1.
  - Elements with index ≥ CLASSES are ignored; this handles the partial last group.
  - After the last group (G = ceil(CLASSES/LANES) groups), the state moves to DONE.
- Insertion rule:
  - The result must equal processing elements one at a time in ascending index order.
  - If top1 is empty, or e > top1, then e becomes top1 and the old top1 moves to top2.
  - Otherwise, if top2 is empty, or e > top2, then e becomes top2.
- Comparisons are strict, so on a tie the lower index wins both slots.
- When the maximum value is duplicated, top2 takes the same value at the next occurrence and margin = 0.
- Comparison sign follows SIGNED.
- margin is computed as sign-extended top1 minus sign-extended top2, in BITWIDTH+1 bits.
- DONE:
  - out_valid = 1, and all result outputs are held stable.
  - On out_valid && out_ready, the state returns to IDLE.
- data_i is ignored outside the IDLE accept cycle, so the source may change it freely after the handshake.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - in_ready = 0; it is registered and rises at the first clk edge after rst_n goes high.
  - out_valid = 0, and all result outputs are 0.
- Latency:
  - Input is accepted at edge T.
  - out_valid rises at edge T+G. With the defaults this is T+5; with LANES = CLASSES it is T+1.
- in_ready falls at edge T and stays low through SCAN and DONE. No second vector can be accepted while out_valid = 1.
- For an output handshake at edge U, out_valid falls at U and in_ready rises at U. The next accept can occur at edge U+1.
- Throughput is one vector per G+2 cycles when the consumer always holds out_ready = 1.
- out_ready may be held low indefinitely. Outputs must not change while stalled.
- If rst_n is asserted mid-SCAN or in DONE, the block aborts immediately, returns all outputs to their reset values, and produces no partial result.

## Structure
- Package argmax_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - the function groups(CLASSES, LANES) = ceil division;
  - the signed/unsigned compare function gt(a, b, signed_mode).
- Sub-module argmax_lane_cmp is a combinational insert unit. It takes the current top1/top2 (value, index, empty flags) and one element with its index, and returns the updated top1/top2.
- The top level chains LANES instances of argmax_lane_cmp per cycle and owns the FSM, the capture register, the group counter and the result registers.

## Test plan
- Defaults, unsigned. data_i scores for indices 0..9 are 09,00,05,02,03,07,08,03,02,01.
  - Required: top1 = (0, 9), top2 = (6, 8), margin = 1.
  - out_valid rises exactly 5 edges after the accept edge.
- Ties. Scores are 03,07,07,01,07,00,00,00,00,00.
  - Required: top1 = (1, 7), top2 = (2, 7), margin = 0.
- SIGNED = 1. Scores are 0x80,0xFF,0xFE,0x80,... with 0x80 at every remaining index.
  - Required: top1 = (1, −1), top2 = (2, −2), margin = 1.
  - Also check that all-0x80 input gives top1 idx 0, top2 idx 1, margin 0.
- LANES = 3 with CLASSES = 10 (partial last group). Maximum score 0x7F at index 9, second 0x10 at index 8.
  - Required: top1 = (9, 0x7F), top2 = (8, 0x10), margin = 0x6F.
  - out_valid rises at T+4.
- Backpressure and abort:
  - Hold out_ready low for 20 cycles. Outputs stay stable, and in_valid pulses are not accepted. in_ready rises at the handshake edge.
  - Assert rst_n mid-SCAN. All outputs go to 0 immediately, and a fresh vector after reset gives the correct result.
